// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory bus arbiter.
// The instruction-fetch port is read-only. The data port is a sized
// load/store port. One transaction is granted at a time, with round-robin
// tie-breaking. Bus attributes are registered on grant and are held for
// the whole transaction. A saturating per-transaction counter ends a hung
// access with an error response.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_I_REQ,
    input  logic [31:0] i_I_ADDR,
    output logic [31:0] o_I_RDATA,
    output logic        o_I_ACK,
    output logic        o_I_ERR,
    input  logic        i_D_REQ,
    input  logic        i_D_WE,
    input  logic [1:0]  i_D_HB,
    input  logic [31:0] i_D_ADDR,
    input  logic [31:0] i_D_WDATA,
    output logic [31:0] o_D_RDATA,
    output logic        o_D_ACK,
    output logic        o_D_ERR,
    output logic        o_BUS_REQ,
    output logic        o_BUS_WE,
    output logic [1:0]  o_BUS_HB,
    output logic [31:0] o_BUS_ADDR,
    output logic [31:0] o_BUS_WDATA,
    input  logic [31:0] i_BUS_RDATA,
    input  logic        i_BUS_ACK
);

    // A zero TIMEOUT disables termination.
    // In that case the counter keeps a 1-bit width so that it stays legal.
    localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t        state_r,     state_nxt_s;
    logic          last_d_r,    last_d_nxt_s;    // 1: last tie went to the data port
    logic [CW-1:0] cnt_r,       cnt_nxt_s;
    logic          ins_ack_r,   ins_ack_nxt_s;
    logic          ins_err_r,   ins_err_nxt_s;
    logic [31:0]   ins_rdata_r, ins_rdata_nxt_s;
    logic          dat_ack_r,   dat_ack_nxt_s;
    logic          dat_err_r,   dat_err_nxt_s;
    logic [31:0]   dat_rdata_r, dat_rdata_nxt_s;
    logic          bus_req_r,   bus_req_nxt_s;
    logic          bus_we_r,    bus_we_nxt_s;
    logic [1:0]    bus_hb_r,    bus_hb_nxt_s;
    logic [31:0]   bus_addr_r,  bus_addr_nxt_s;
    logic [31:0]   bus_wdata_r, bus_wdata_nxt_s;

    logic elig_i_s, elig_d_s, grant_i_s, grant_d_s, timeout_hit_s;

    // Saturating increment, so the counter never wraps back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CW'(1'b1);
        end
        return r;
    endfunction

    // The counter holds the number of BUSY cycles already spent without an ack.
    // Termination fires in the BUSY cycle where that count equals TIMEOUT.
    // An ack arriving in that same cycle still wins.
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (cnt_r == CNT_TO);

    // Eligibility masks a port whose ack is being presented this cycle.
    // On a tie the grant goes to the port opposite the last tie winner.
    always_comb begin
        elig_i_s  = i_I_REQ & ~ins_ack_r;
        elig_d_s  = i_D_REQ & ~dat_ack_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (elig_i_s && elig_d_s) begin
                grant_i_s = last_d_r;
                grant_d_s = ~last_d_r;
            end else begin
                grant_i_s = elig_i_s;
                grant_d_s = elig_d_s;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Next-state logic: grant, completion, timeout, and all registered outputs.
    always_comb begin
        state_nxt_s     = state_r;
        last_d_nxt_s    = last_d_r;
        cnt_nxt_s       = cnt_r;
        ins_ack_nxt_s   = 1'b0;
        ins_err_nxt_s   = 1'b0;
        ins_rdata_nxt_s = ins_rdata_r;
        dat_ack_nxt_s   = 1'b0;
        dat_err_nxt_s   = 1'b0;
        dat_rdata_nxt_s = dat_rdata_r;
        bus_req_nxt_s   = bus_req_r;
        bus_we_nxt_s    = bus_we_r;
        bus_hb_nxt_s    = bus_hb_r;
        bus_addr_nxt_s  = bus_addr_r;
        bus_wdata_nxt_s = bus_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (elig_i_s && elig_d_s) begin
                    last_d_nxt_s = grant_d_s;
                end else begin
                    last_d_nxt_s = last_d_r;
                end
                if (grant_i_s) begin
                    state_nxt_s     = ST_BUSY_I;
                    cnt_nxt_s       = {CW{1'b0}};
                    bus_req_nxt_s   = 1'b1;
                    bus_we_nxt_s    = 1'b0;
                    bus_hb_nxt_s    = 2'b10;
                    bus_addr_nxt_s  = i_I_ADDR;
                    bus_wdata_nxt_s = 32'h0000_0000;
                end else if (grant_d_s) begin
                    state_nxt_s     = ST_BUSY_D;
                    cnt_nxt_s       = {CW{1'b0}};
                    bus_req_nxt_s   = 1'b1;
                    bus_we_nxt_s    = i_D_WE;
                    bus_hb_nxt_s    = i_D_HB;
                    bus_addr_nxt_s  = i_D_ADDR;
                    bus_wdata_nxt_s = i_D_WDATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (i_BUS_ACK) begin
                    state_nxt_s     = ST_IDLE;
                    bus_req_nxt_s   = 1'b0;
                    ins_ack_nxt_s   = 1'b1;
                    ins_rdata_nxt_s = i_BUS_RDATA;
                end else if (timeout_hit_s) begin
                    state_nxt_s     = ST_IDLE;
                    bus_req_nxt_s   = 1'b0;
                    ins_ack_nxt_s   = 1'b1;
                    ins_err_nxt_s   = 1'b1;
                    ins_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_BUSY_D: begin
                if (i_BUS_ACK) begin
                    state_nxt_s     = ST_IDLE;
                    bus_req_nxt_s   = 1'b0;
                    dat_ack_nxt_s   = 1'b1;
                    dat_rdata_nxt_s = bus_we_r ? 32'h0000_0000 : i_BUS_RDATA;
                end else if (timeout_hit_s) begin
                    state_nxt_s     = ST_IDLE;
                    bus_req_nxt_s   = 1'b0;
                    dat_ack_nxt_s   = 1'b1;
                    dat_err_nxt_s   = 1'b1;
                    dat_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                bus_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    // An asynchronous reset abandons any transaction in flight.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_r     <= ST_IDLE;
            last_d_r    <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            ins_ack_r   <= 1'b0;
            ins_err_r   <= 1'b0;
            ins_rdata_r <= 32'h0000_0000;
            dat_ack_r   <= 1'b0;
            dat_err_r   <= 1'b0;
            dat_rdata_r <= 32'h0000_0000;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_hb_r    <= 2'b00;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            last_d_r    <= last_d_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ins_ack_r   <= ins_ack_nxt_s;
            ins_err_r   <= ins_err_nxt_s;
            ins_rdata_r <= ins_rdata_nxt_s;
            dat_ack_r   <= dat_ack_nxt_s;
            dat_err_r   <= dat_err_nxt_s;
            dat_rdata_r <= dat_rdata_nxt_s;
            bus_req_r   <= bus_req_nxt_s;
            bus_we_r    <= bus_we_nxt_s;
            bus_hb_r    <= bus_hb_nxt_s;
            bus_addr_r  <= bus_addr_nxt_s;
            bus_wdata_r <= bus_wdata_nxt_s;
        end
    end

    assign o_I_ACK     = ins_ack_r;
    assign o_I_ERR     = ins_err_r;
    assign o_I_RDATA   = ins_rdata_r;
    assign o_D_ACK     = dat_ack_r;
    assign o_D_ERR     = dat_err_r;
    assign o_D_RDATA   = dat_rdata_r;
    assign o_BUS_REQ   = bus_req_r;
    assign o_BUS_WE    = bus_we_r;
    assign o_BUS_HB    = bus_hb_r;
    assign o_BUS_ADDR  = bus_addr_r;
    assign o_BUS_WDATA = bus_wdata_r;

endmodule
